power_fsm: RTL and testbench
============================

Name: power_fsm

Overview:
- Board power-sequencing state machine in the CPLD.
- After a one-cycle start request it enables board power, or keeps it off when initial_pwr_off is set.
- A long press of the power button turns power off; a later press turns it back on.
- Button timing runs on the system slow-clock enable (ce), so delays are counted in ce ticks, not clk cycles.

Parameters:
- LONG_PRESS_DELAY, 3'd7, 3-bit count of consecutive ce ticks with pwr_btn high that make a long press. Legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  slow-clock enable, one clk cycle wide, periodic.
- start  in  1  one-clk pulse that leaves IDLE; sampled every clk, independent of ce.
- initial_pwr_off  in  1  sampled together with start; 1 means stay off after start.
- pwr_btn  in  1  power button, active high, already synchronized and debounced upstream.
- pwr_enable  out  1  registered; 1 means board power is on.

Behaviour:
- States: IDLE, ON_WAIT_RELEASE, ON, OFF_WAIT_RELEASE, OFF.
- 3-bit press counter cnt.
- Reset (rst=1 at a clk edge):
  - state=IDLE, cnt=0, pwr_enable=0.
  - Reset overrides every other input and works from any state.
- IDLE:
  - pwr_enable=0; ce and pwr_btn are ignored.
  - On a clk where start=1: go to OFF_WAIT_RELEASE if initial_pwr_off=1, else ON_WAIT_RELEASE.
  - pwr_enable is registered, so it goes to 1 on the clk after start.
- start is ignored in every state except IDLE.
- Outside IDLE, state and cnt change only on clk cycles with ce=1. On ce=0 cycles everything holds.
- ON_WAIT_RELEASE:
  - pwr_enable=1, cnt=0.
  - On a ce tick with pwr_btn=0, go to ON.
  - This stops a still-held button from immediately counting as a long press.
- ON:
  - pwr_enable=1.
  - On a ce tick with pwr_btn=1:
    - if cnt==LONG_PRESS_DELAY-1: go to OFF_WAIT_RELEASE, cnt=0, pwr_enable=0 from the next clk;
    - otherwise cnt=cnt+1.
  - On a ce tick with pwr_btn=0: cnt=0, so a short press is discarded.
  - Result: power drops exactly on the LONG_PRESS_DELAY-th consecutive ce sample of pwr_btn=1.
- OFF_WAIT_RELEASE:
  - pwr_enable=0, cnt=0.
  - On a ce tick with pwr_btn=0, go to OFF.
- OFF:
  - pwr_enable=0.
  - On a ce tick with pwr_btn=1, go to ON_WAIT_RELEASE; pwr_enable=1 from the next clk.
  - Any press length turns power on.
- Button changes between ce ticks are invisible; only ce-cycle samples count.
- Simultaneous events:
  - start and ce in the same clk while in IDLE: the start transition wins; the ce tick is not used for button sampling.
  - rst together with anything: reset wins.
- cnt never exceeds LONG_PRESS_DELAY-1, so there is no wrap-around.
- pwr_enable is a pure function of state: 1 in ON and ON_WAIT_RELEASE, 0 otherwise.

Test Plan:
- Bench setup for all scenarios: LONG_PRESS_DELAY=5, ce every 10 clk.
- Reset, then hold start=0 for 100 clk -> pwr_enable stays 0, state stays IDLE, button presses have no effect.
- Reset, start pulse with initial_pwr_off=0, pwr_btn=0 -> pwr_enable=1 one clk after start; stays 1 for 1000 clk.
- From ON, pwr_btn=1 for 4 ce ticks, then 0 -> pwr_enable stays 1. Then hold pwr_btn=1 for 7 ticks -> pwr_enable falls to 0 right after the 5th ce sample and stays 0 while the button is held.
- From OFF with button released, press pwr_btn for one ce tick -> pwr_enable=1 on the next clk. Keep holding for 10 more ticks -> pwr_enable stays 1 until release, then a fresh 5-tick press is needed to turn off.
- Start pulse with initial_pwr_off=1 -> pwr_enable stays 0. A press turns power on; a second start pulse while powered causes no change.
- Assert rst while in ON with cnt=3 -> next clk pwr_enable=0, state IDLE. A later start behaves as after power-up.

Source files
------------

// File: rtl/power_fsm.sv
// power_fsm: board power sequencer with start request and long-press power-off button
module power_fsm #(
  parameter logic [2:0] LONG_PRESS_DELAY = 3'd7
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic start,
  input  logic initial_pwr_off,
  input  logic pwr_btn,
  output logic pwr_enable
);
  typedef enum logic [2:0] {IDLE, ON_WAIT_RELEASE, ON, OFF_WAIT_RELEASE, OFF} state_t;
  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_pwr_enable;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_pwr_enable <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pwr_enable <= (w_state_nxt == ON) || (w_state_nxt == ON_WAIT_RELEASE);
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == IDLE) begin
      w_cnt_nxt = 3'd0;
      if (start) w_state_nxt = initial_pwr_off ? OFF_WAIT_RELEASE : ON_WAIT_RELEASE;
    end else if (ce) begin
      case (r_state)
        ON_WAIT_RELEASE: begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = pwr_btn ? ON_WAIT_RELEASE : ON;
        end
        ON: begin
          if (!pwr_btn) w_cnt_nxt = 3'd0;
          else if (r_cnt == LONG_PRESS_DELAY - 3'd1) begin
            w_cnt_nxt   = 3'd0;
            w_state_nxt = OFF_WAIT_RELEASE;
          end else w_cnt_nxt = r_cnt + 3'd1;
        end
        OFF_WAIT_RELEASE: begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = pwr_btn ? OFF_WAIT_RELEASE : OFF;
        end
        OFF: begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = pwr_btn ? ON_WAIT_RELEASE : OFF;
        end
        default: begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end
  assign pwr_enable = r_pwr_enable;
endmodule

// File: tb/tb_power_fsm.sv
// tb_power_fsm: directed scenarios for power_fsm with LONG_PRESS_DELAY=5 and ce every 10 clk
module tb_power_fsm;
  logic clk = 1'b0, rst = 1'b0, ce = 1'b0, start = 1'b0, initial_pwr_off = 1'b0, pwr_btn = 1'b0;
  logic pwr_enable;
  int checks = 0, errors = 0;
  power_fsm #(.LONG_PRESS_DELAY(3'd5)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .initial_pwr_off(initial_pwr_off), .pwr_btn(pwr_btn), .pwr_enable(pwr_enable)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic tick(input logic b, input logic glitch);
    pwr_btn = glitch ? 1'b1 : b;
    ce = 1'b0;
    repeat (9) @(negedge clk);
    pwr_btn = b;
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask
  task automatic pulse_start(input logic off);
    initial_pwr_off = off;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    initial_pwr_off = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (pwr_enable !== 1'b0) begin errors++; $display("FAIL reset_value: pwr_enable=%b expected 0", pwr_enable); end
    for (int i = 0; i < 10; i++) begin
      tick(i[0], 1'b0);
      checks++;
      if (pwr_enable !== 1'b0) begin errors++; $display("FAIL idle_hold tick %0d: pwr_enable=%b expected 0", i, pwr_enable); end
    end
  endtask
  task automatic test_power_on();
    do_reset();
    pulse_start(1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL on_after_start: pwr_enable=%b expected 1", pwr_enable); end
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (pwr_enable !== 1'b1) begin errors++; $display("FAIL on_hold tick %0d: pwr_enable=%b expected 1", i, pwr_enable); end
    end
  endtask
  task automatic test_long_press();
    logic e;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL short_press4: pwr_enable=%b expected 1", pwr_enable); end
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL glitch_reset_cnt: pwr_enable=%b expected 1", pwr_enable); end
    tick(1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick(1'b1, 1'b0);
      e = (i < 5);
      checks++;
      if (pwr_enable !== e) begin errors++; $display("FAIL long_press tick %0d: pwr_enable=%b expected %b", i, pwr_enable, e); end
    end
  endtask
  task automatic test_off_press();
    logic e;
    tick(1'b0, 1'b0);
    checks++;
    if (pwr_enable !== 1'b0) begin errors++; $display("FAIL off_released: pwr_enable=%b expected 0", pwr_enable); end
    tick(1'b1, 1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL off_press_on: pwr_enable=%b expected 1", pwr_enable); end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL on_wait_held: pwr_enable=%b expected 1", pwr_enable); end
    tick(1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 1'b0);
      e = (i < 5);
      checks++;
      if (pwr_enable !== e) begin errors++; $display("FAIL fresh_press tick %0d: pwr_enable=%b expected %b", i, pwr_enable, e); end
    end
  endtask
  task automatic test_initial_off();
    do_reset();
    pulse_start(1'b1);
    checks++;
    if (pwr_enable !== 1'b0) begin errors++; $display("FAIL initial_off_start: pwr_enable=%b expected 0", pwr_enable); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (pwr_enable !== 1'b0) begin errors++; $display("FAIL initial_off_hold: pwr_enable=%b expected 0", pwr_enable); end
    tick(1'b1, 1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL initial_off_press: pwr_enable=%b expected 1", pwr_enable); end
    tick(1'b0, 1'b0);
    pulse_start(1'b1);
    tick(1'b0, 1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL start_ignored: pwr_enable=%b expected 1", pwr_enable); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    pwr_btn = 1'b1;
    ce = 1'b1;
    pulse_start(1'b0);
    ce = 1'b0;
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL start_with_ce: pwr_enable=%b expected 1", pwr_enable); end
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL held_after_start: pwr_enable=%b expected 1", pwr_enable); end
    rst = 1'b1;
    pulse_start(1'b0);
    rst = 1'b0;
    checks++;
    if (pwr_enable !== 1'b0) begin errors++; $display("FAIL rst_over_start: pwr_enable=%b expected 0", pwr_enable); end
  endtask
  task automatic test_reset_midpress();
    logic e;
    do_reset();
    pulse_start(1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    pwr_btn = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pwr_enable !== 1'b0) begin errors++; $display("FAIL rst_midpress: pwr_enable=%b expected 0", pwr_enable); end
    for (int i = 0; i < 4; i++) tick(i[0], 1'b0);
    checks++;
    if (pwr_enable !== 1'b0) begin errors++; $display("FAIL idle_after_rst: pwr_enable=%b expected 0", pwr_enable); end
    pwr_btn = 1'b0;
    pulse_start(1'b0);
    checks++;
    if (pwr_enable !== 1'b1) begin errors++; $display("FAIL restart_on: pwr_enable=%b expected 1", pwr_enable); end
    tick(1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 1'b0);
      e = (i < 5);
      checks++;
      if (pwr_enable !== e) begin errors++; $display("FAIL restart_press tick %0d: pwr_enable=%b expected %b", i, pwr_enable, e); end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_power_on();
    test_long_press();
    test_off_press();
    test_initial_off();
    test_simultaneous();
    test_reset_midpress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
